ad_sample_sched: RTL and testbench

- Shares the single ADS7822 converter front-end between two requesters:
  - the periodic frame sampler (fiber transmit trigger);
  - a slow on-demand diagnostic/calibration requester.
- Issues the AD_trigger pulse train to the converter driver and supervises each conversion with a timeout.
- Routes the returned 12-bit sample to the requester that owns the slot, and reports overruns and converter faults to the fault path.

---
 rtl/ad_sample_sched.sv | 110 +++++++++++
 tb/tb_ad_sample_sched.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ad_sample_sched.sv
// ad_sample_sched: shares one ADS7822 front-end between the frame sampler and the diagnostic requester
module ad_sample_sched #(
  parameter int TRIG_CYC    = 4,
  parameter int TIMEOUT_CYC = 800,
  parameter int GAP_CYC     = 40
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        reset_unit,
  input  logic        frame_req,
  input  logic        diag_req,
  input  logic [11:0] sample_data,
  input  logic        data_valid,
  output logic        AD_trigger,
  output logic [11:0] frame_data,
  output logic        frame_valid,
  output logic [11:0] diag_data,
  output logic        diag_ack,
  output logic        busy,
  output logic        ad_timeout_err,
  output logic [7:0]  overrun_cnt
);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT, DONE, GAP} state_t;
  state_t      state_q;
  logic        frame_pend_q, owner_frame_q, ad_trigger_q, frame_valid_q, diag_ack_q, busy_q, ad_timeout_err_q;
  logic [11:0] frame_data_q, diag_data_q, to_cnt_q;
  logic [7:0]  cnt_q, overrun_cnt_q;
  logic        take_frame, trig_last, to_hit, gap_last;
  // a frame pulse arriving in IDLE is served at once, ahead of a waiting diagnostic request
  assign take_frame = (state_q == IDLE) && (frame_pend_q || frame_req);
  assign trig_last  = cnt_q == 8'(TRIG_CYC - 1);
  assign to_hit     = to_cnt_q >= 12'(TIMEOUT_CYC - 1);
  assign gap_last   = {1'b0, cnt_q} + 9'd1 >= 9'(GAP_CYC);
  assign AD_trigger     = ad_trigger_q;
  assign frame_data     = frame_data_q;
  assign frame_valid    = frame_valid_q;
  assign diag_data      = diag_data_q;
  assign diag_ack       = diag_ack_q;
  assign busy           = busy_q;
  assign ad_timeout_err = ad_timeout_err_q;
  assign overrun_cnt    = overrun_cnt_q;
  // scheduler: arbitration, trigger timing, timeout supervision and result routing
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q          <= IDLE;
      frame_pend_q     <= 1'b0;
      owner_frame_q    <= 1'b0;
      ad_trigger_q     <= 1'b0;
      frame_valid_q    <= 1'b0;
      diag_ack_q       <= 1'b0;
      busy_q           <= 1'b0;
      ad_timeout_err_q <= 1'b0;
      frame_data_q     <= '0;
      diag_data_q      <= '0;
      to_cnt_q         <= '0;
      cnt_q            <= '0;
      overrun_cnt_q    <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      diag_ack_q    <= 1'b0;
      if (frame_req && frame_pend_q && overrun_cnt_q != 8'hFF) overrun_cnt_q <= overrun_cnt_q + 8'd1;
      frame_pend_q <= !take_frame && (frame_pend_q || frame_req);
      if (reset_unit) ad_timeout_err_q <= 1'b0;
      case (state_q)
        IDLE: if (take_frame || diag_req) begin
          state_q       <= TRIG;
          owner_frame_q <= take_frame;
          ad_trigger_q  <= 1'b1;
          busy_q        <= 1'b1;
          cnt_q         <= '0;
          to_cnt_q      <= '0;
        end
        TRIG, WAIT: begin
          cnt_q    <= cnt_q + 8'd1;
          to_cnt_q <= to_cnt_q + 12'd1;
          if (data_valid) begin
            state_q      <= DONE;
            ad_trigger_q <= 1'b0;
            if (owner_frame_q) begin
              frame_data_q  <= sample_data;
              frame_valid_q <= 1'b1;
            end else begin
              diag_data_q <= sample_data;
              diag_ack_q  <= 1'b1;
            end
          end else if (state_q == TRIG && trig_last) begin
            state_q      <= WAIT;
            ad_trigger_q <= 1'b0;
          end else if (state_q == WAIT && to_hit) begin
            state_q          <= GAP;
            cnt_q            <= '0;
            ad_timeout_err_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= GAP;
          cnt_q   <= '0;
        end
        GAP: begin
          cnt_q <= cnt_q + 8'd1;
          if (gap_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ad_sample_sched.sv
// tb_ad_sample_sched: directed stimulus with a timestamp-based reference model checked every cycle
module tb_ad_sample_sched;
  localparam int TRIG_CYC = 4, TIMEOUT_CYC = 800, GAP_CYC = 40;
  localparam int GAP_LEN = (GAP_CYC == 0) ? 1 : GAP_CYC;
  logic clk = 1'b0, Reset = 1'b1, reset_unit = 1'b0, frame_req = 1'b0, diag_req = 1'b0, data_valid = 1'b0;
  logic [11:0] sample_data = '0;
  logic AD_trigger, frame_valid, diag_ack, busy, ad_timeout_err;
  logic [11:0] frame_data, diag_data;
  logic [7:0] overrun_cnt;
  logic [36:0] outs, m_exp;
  int checks = 0, failures = 0;
  ad_sample_sched #(.TRIG_CYC(TRIG_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .Reset(Reset), .reset_unit(reset_unit), .frame_req(frame_req), .diag_req(diag_req),
    .sample_data(sample_data), .data_valid(data_valid), .AD_trigger(AD_trigger), .frame_data(frame_data),
    .frame_valid(frame_valid), .diag_data(diag_data), .diag_ack(diag_ack), .busy(busy),
    .ad_timeout_err(ad_timeout_err), .overrun_cnt(overrun_cnt)
  );
  assign outs = {AD_trigger, frame_valid, diag_ack, busy, ad_timeout_err, frame_data, diag_data, overrun_cnt};
  initial forever #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_trig(input int budget, output int k);
    k = 0;
    while (AD_trigger !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask
  task automatic give(input logic [11:0] d);
    data_valid = 1'b1;
    sample_data = d;
    step(1);
    data_valid = 1'b0;
    sample_data = '0;
  endtask
  // reference model: each conversion is a time window measured from the trigger-rise edge
  logic m_armed = 0, m_active = 0, m_done = 0, m_pend = 0, m_owner = 0, m_took = 0, m_err = 0, m_fv = 0, m_da = 0;
  int m_n = 0, m_t0 = 0, m_idle_at = 0;
  logic [7:0] m_ovr = '0;
  logic [11:0] m_fd = '0, m_dd = '0;
  always @(posedge clk) begin
    m_n++;
    m_fv = 0;
    m_da = 0;
    if (Reset) begin
      m_armed = 1; m_active = 0; m_pend = 0; m_ovr = '0; m_err = 0; m_fd = '0; m_dd = '0;
    end else begin
      m_took = !m_active && (m_pend || frame_req);
      if (frame_req && m_pend) m_ovr = (m_ovr == 8'd255) ? 8'd255 : m_ovr + 8'd1;
      if (reset_unit) m_err = 0;
      if (!m_active) begin
        if (m_pend || frame_req || diag_req) begin
          m_active = 1; m_done = 0; m_t0 = m_n; m_owner = m_took;
        end
      end else if (!m_done) begin
        if (data_valid) begin
          m_done = 1;
          m_idle_at = m_n + 1 + GAP_LEN;
          if (m_owner) begin m_fd = sample_data; m_fv = 1; end
          else begin m_dd = sample_data; m_da = 1; end
        end else if (m_n - m_t0 >= TIMEOUT_CYC) begin
          m_done = 1;
          m_err = 1;
          m_idle_at = m_n + GAP_LEN;
        end
      end else if (m_n == m_idle_at) m_active = 0;
      m_pend = m_took ? 1'b0 : (m_pend || frame_req);
    end
  end
  always @(negedge clk) if (m_armed) begin
    m_exp = {m_active && !m_done && (m_n - m_t0) < TRIG_CYC, m_fv, m_da, m_active, m_err, m_fd, m_dd, m_ovr};
    checks++;
    if (outs !== m_exp) begin
      failures++;
      $display("FAIL model_cycle%0d actual=0x%h required=0x%h", m_n, outs, m_exp);
    end
  end
  logic ad_prev = 1'b0;
  int rises = 0;
  always @(negedge clk) begin
    if (AD_trigger && !ad_prev) rises++;
    ad_prev = AD_trigger;
  end
  int k, r0;
  initial begin
    step(3);
    chk("reset_state", outs, 0);
    Reset = 1'b0;
    step(2);
    frame_req = 1'b1; step(1); frame_req = 1'b0;
    chk("t1_trig_rise", AD_trigger, 1);
    chk("t1_busy", busy, 1);
    step(3); chk("t1_trig_hold4", AD_trigger, 1);
    step(1); chk("t1_trig_fall", AD_trigger, 0);
    step(25); give(12'hA5C);
    chk("t1_frame_valid", frame_valid, 1);
    chk("t1_frame_data", frame_data, 12'hA5C);
    step(1); chk("t1_valid_one_cycle", frame_valid, 0);
    give(12'hFFF);
    chk("t1_gap_data_ignored", {frame_valid, frame_data}, {1'b0, 12'hA5C});
    step(38); chk("t1_busy_gap_end", busy, 1);
    step(1); chk("t1_busy_fall", busy, 0);
    step(3);
    diag_req = 1'b1; frame_req = 1'b1; step(1); frame_req = 1'b0;
    chk("t2_frame_first", AD_trigger, 1);
    step(9); give(12'h123);
    chk("t2_frame", {frame_valid, diag_ack, frame_data}, {1'b1, 1'b0, 12'h123});
    wait_trig(100, k);
    chk("t2_diag_start_delay", k, 42);
    step(19); give(12'h456); diag_req = 1'b0;
    chk("t2_diag", {diag_ack, frame_valid, diag_data, frame_data}, {1'b1, 1'b0, 12'h456, 12'h123});
    step(1); chk("t2_ack_one_cycle", diag_ack, 0);
    step(50); chk("t2_idle", busy, 0);
    frame_req = 1'b1; step(1); frame_req = 1'b0;
    step(799); chk("t3_err_before", ad_timeout_err, 0);
    step(1); chk("t3_err_set", {ad_timeout_err, frame_valid, busy}, {1'b1, 1'b0, 1'b1});
    step(45); chk("t3_idle", busy, 0);
    frame_req = 1'b1; step(1); frame_req = 1'b0;
    step(4); give(12'h7E1);
    chk("t3_next_ok", {frame_valid, frame_data, ad_timeout_err}, {1'b1, 12'h7E1, 1'b1});
    step(50);
    reset_unit = 1'b1; step(1); reset_unit = 1'b0;
    chk("t3_err_clear", ad_timeout_err, 0);
    diag_req = 1'b1; step(1); diag_req = 1'b0;
    chk("t7_diag_start", AD_trigger, 1);
    step(9); give(12'h3C9);
    chk("t7_dropped_req_acked", {diag_ack, frame_valid, diag_data}, {1'b1, 1'b0, 12'h3C9});
    step(50);
    r0 = rises;
    frame_req = 1'b1; step(1); frame_req = 1'b0;
    repeat (3) begin step(1); frame_req = 1'b1; step(1); frame_req = 1'b0; end
    chk("t4_overrun2", overrun_cnt, 2);
    step(4); give(12'h0AA);
    chk("t4_first", {frame_valid, frame_data}, {1'b1, 12'h0AA});
    wait_trig(100, k);
    chk("t4_second_start_delay", k, 42);
    step(5); give(12'h0BB);
    chk("t4_second", {frame_valid, frame_data}, {1'b1, 12'h0BB});
    step(100);
    chk("t4_two_conversions", rises - r0, 2);
    reset_unit = 1'b1; step(1); reset_unit = 1'b0;
    chk("t4_overrun_kept", overrun_cnt, 2);
    repeat (300) begin frame_req = 1'b1; step(1); frame_req = 1'b0; step(1); end
    chk("t5_overrun_sat", {overrun_cnt, ad_timeout_err, busy}, {8'd255, 1'b0, 1'b1});
    Reset = 1'b1; step(1); Reset = 1'b0;
    chk("t6_reset_all", outs, 0);
    step(30); chk("t6_pend_lost", {busy, AD_trigger}, 0);
    give(12'hABC);
    chk("t6_late_valid_ignored", {frame_valid, diag_ack, frame_data}, 0);
    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
